// File: rtl/alu_exec_if.sv
// Handshake and operand/result bus for the alu_exec execute unit.
// The master launches operations; the slave (alu_exec) returns results.
interface alu_exec_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       aluopration;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, aluopration, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, aluopration, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec.sv
// Registered MIPS32 execute unit: single-cycle logic/arith ops plus an optional
// 32-cycle shift-add multiplier compiled in when ALU_MULT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; latches operands and opcode on acceptance
// EXEC  | registers result/flags of a simple op and pulses done
// MUL   | shift-add iteration, one multiplier bit per cycle (ALU_MULT_EN only)
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);

`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  localparam int CW = $clog2(WIDTH + 1);
`else
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, overflow_q, done_q;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = EXEC;
`ifdef ALU_MULT_EN
          if (bus.aluopration == 4'b1001) state_nxt = MUL;
`endif
        end
      end
      EXEC: state_nxt = IDLE;
`ifdef ALU_MULT_EN
      MUL: if (cnt == CW'(1)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      4'b0000: alu_res = a_q & b_q;
      4'b0001: alu_res = a_q | b_q;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'b1000: alu_res = b_q << 16;
      4'b1100: alu_res = ~(a_q | b_q);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULT_EN
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef ALU_MULT_EN
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.aluopration;
            a_q  <= bus.a;
            b_q  <= bus.b;
`ifdef ALU_MULT_EN
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= (bus.aluopration == 4'b1001) ? CW'(WIDTH) : '0;
`endif
          end
        end
        EXEC: begin
          result_q   <= alu_res;
          zero_q     <= (alu_res == '0);
          overflow_q <= alu_ovf;
          done_q     <= 1'b1;
        end
`ifdef ALU_MULT_EN
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // last iteration: the accumulator including this step's addend is final
          if (cnt == CW'(1)) begin
            result_q   <= acc_nxt;
            zero_q     <= (acc_nxt == '0);
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_exec;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_exec_if #(.WIDTH(WIDTH)) bus();

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; v = 1'b0; lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = {b[15:0], 16'h0000};
      4'd12: r = ~(a | b);
`ifdef ALU_MULT_EN
      4'd9:  begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; lat = 32; end
`endif
      default: r = 32'h0;
    endcase
  endfunction

  // Launch one op and wait (bounded) for done; also checks busy after E0 and
  // that done drops and result holds on the following cycle.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic z,
                        output logic ovf, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.aluopration = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    chk({name, " busy_after_E0"}, {31'h0, bus.busy}, 32'd1);
    bus.start = 1'b0; bus.aluopration = ~op; bus.a = ~a; bus.b = ~b;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    res = bus.result; z = bus.zero; ovf = bus.overflow;
    @(posedge clk); #1;
    chk({name, " done_clears"}, {31'h0, bus.done}, 32'd0);
    chk({name, " result_held"}, bus.result, res);
  endtask

  logic [31:0] r, er;
  logic        z, v, ev;
  int          lat, elat, ndone;
  logic [3:0]  ops[10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12, 4'd9, 4'd15, 4'd3};

  initial begin
    bus.start = 1'b0; bus.aluopration = 4'h0; bus.a = '0; bus.b = '0;

    vecs[0] = '{4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0, 1};
    vecs[1] = '{4'b0110, 32'h1234,     32'h1234,     32'h0,        1'b0, 1'b1, 1};
    vecs[2] = '{4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1};
    vecs[3] = '{4'b1000, 32'h0,        32'hABCD,     32'hABCD0000, 1'b0, 1'b0, 1};
    vecs[4] = '{4'b1111, 32'h5,        32'h7,        32'h0,        1'b0, 1'b1, 1};
`ifdef ALU_MULT_EN
    vecs[5] = '{4'b1001, 32'hFFFF,     32'h10001,    32'hFFFFFFFF, 1'b0, 1'b0, 32};
`else
    vecs[5] = '{4'b1001, 32'hFFFF,     32'h10001,    32'h0,        1'b0, 1'b1, 1};
`endif
    vecs[6] = '{4'b1100, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0, 1};
    vecs[7] = '{4'b0110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0, 1};
    vecs[8] = '{4'b0000, 32'hF0,       32'h0F,       32'h0,        1'b0, 1'b1, 1};

    #12;
    chk("reset busy",     {31'h0, bus.busy},     32'd0);
    chk("reset done",     {31'h0, bus.done},     32'd0);
    chk("reset result",   bus.result,            32'h0);
    chk("reset zero",     {31'h0, bus.zero},     32'd1);
    chk("reset overflow", {31'h0, bus.overflow}, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, r, z, v, lat);
      chk($sformatf("vec%0d result", i),  r, vecs[i].res);
      chk($sformatf("vec%0d zero", i),    {31'h0, z}, {31'h0, vecs[i].z});
      chk($sformatf("vec%0d overflow", i), {31'h0, v}, {31'h0, vecs[i].ovf});
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // start held high through EXEC: second op only accepted once back in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.aluopration = 4'b0001; bus.a = 32'hF0; bus.b = 32'h0F;
    @(posedge clk); #1;
    bus.aluopration = 4'b0000;
    @(posedge clk); #1;
    chk("hold E1 done",   {31'h0, bus.done}, 32'd1);
    chk("hold E1 result", bus.result, 32'hFF);
    @(posedge clk); #1;
    chk("hold E2 done",   {31'h0, bus.done}, 32'd0);
    chk("hold E2 busy",   {31'h0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("hold E3 done",   {31'h0, bus.done}, 32'd1);
    chk("hold E3 result", bus.result, 32'h0);
    chk("hold E3 zero",   {31'h0, bus.zero}, 32'd1);

    for (int n = 0; n < 30; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 9)];
      a  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
      model(op, a, b, er, ev, elat);
      run_op($sformatf("rnd%0d", n), op, a, b, r, z, v, lat);
      chk($sformatf("rnd%0d op%0d result", n, op), r, er);
      chk($sformatf("rnd%0d zero", n),     {31'h0, z}, {31'h0, (er == 32'h0)});
      chk($sformatf("rnd%0d overflow", n), {31'h0, v}, {31'h0, ev});
      chk($sformatf("rnd%0d latency", n),  32'(lat), 32'(elat));
    end

    // make the result nonzero so the reset clear is observable
    run_op("pre_rst", 4'b0001, 32'h1, 32'h2, r, z, v, lat);
    chk("pre_rst result", r, 32'h3);
    @(negedge clk);
`ifdef ALU_MULT_EN
    bus.start = 1'b1; bus.aluopration = 4'b1001; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`else
    bus.start = 1'b1; bus.aluopration = 4'b0010; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst busy",   {31'h0, bus.busy}, 32'd0);
    chk("mid_rst result", bus.result, 32'h0);
    chk("mid_rst zero",   {31'h0, bus.zero}, 32'd1);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("mid_rst no_done", 32'(ndone), 32'd0);
    chk("mid_rst result_after", bus.result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
